// File: rtl/arm_pkg.sv
// ============================================================================
// Module  : arm_pkg
// Brief   : Shared constants for the ARM register bank: architectural register
//           aliases, NZCV bit positions and the default PC advance.
// Revision: 1.0
// ============================================================================
`default_nettype none

package arm_pkg;

    localparam int REG_SP          = 13;
    localparam int REG_LR          = 14;
    localparam int REG_PC          = 15;

    localparam int NZCV_N          = 3;
    localparam int NZCV_Z          = 2;
    localparam int NZCV_C          = 1;
    localparam int NZCV_V          = 0;

    localparam int PC_STEP_DEFAULT = 4;

    typedef logic [3:0] nzcv_t;

endpackage

`default_nettype wire

// File: rtl/arm_rf_read_port.sv
// ============================================================================
// Module  : arm_rf_read_port
// Brief   : One register-file read port: PC select, A/B writeback bypass and
//           scoreboard busy term for decode stalls.
// Revision: 1.0
// ============================================================================
`default_nettype none

module arm_rf_read_port #(
    parameter int N       = 32,
    parameter int AW      = 4,
    parameter int PC_ADDR = 15
) (
    input  logic [AW-1:0] i_addr,
    input  logic [N-1:0]  i_stored,
    input  logic [N-1:0]  i_pc_read,
    input  logic          i_busy,
    input  logic          i_wa_en,
    input  logic [AW-1:0] i_wa_addr,
    input  logic [N-1:0]  i_wa_data,
    input  logic          i_wb_en,
    input  logic [AW-1:0] i_wb_addr,
    input  logic [N-1:0]  i_wb_data,
    input  logic          i_claim_en,
    input  logic [AW-1:0] i_claim_addr,
    output logic [N-1:0]  o_data,
    output logic          o_busy
);

    logic w_is_pc;
    logic w_wa_hit;
    logic w_wb_hit;
    logic w_claim_hit;

    assign w_is_pc     = (i_addr == AW'(PC_ADDR));
    assign w_wa_hit    = i_wa_en    && (i_wa_addr    == i_addr);
    assign w_wb_hit    = i_wb_en    && (i_wb_addr    == i_addr);
    assign w_claim_hit = i_claim_en && (i_claim_addr == i_addr);

    // The PC is never bypassed: readers always see the pipelined fetch address.
    always_comb begin
        o_data = i_stored;
        if (w_is_pc) begin
            o_data = i_pc_read;
        end else if (w_wa_hit) begin
            o_data = i_wa_data;
        end else if (w_wb_hit) begin
            o_data = i_wb_data;
        end
    end

    // Busy reflects the scoreboard after this cycle's writes and claim.
    assign o_busy = (i_busy && !(w_wa_hit || w_wb_hit)) || w_claim_hit;

endmodule

`default_nettype wire

// File: rtl/arm_reg_bank_pipe.sv
// ============================================================================
// Module  : arm_reg_bank_pipe
// Brief   : GPR bank with PC and NZCV flags, NRD bypassed read ports, two
//           writeback ports (A wins over B) and a busy scoreboard.
// Revision: 1.0
// ============================================================================
`default_nettype none

module arm_reg_bank_pipe
    import arm_pkg::*;
#(
    parameter int N       = 32,
    parameter int NREGS   = 16,
    parameter int NRD     = 3,
    parameter int PC_STEP = PC_STEP_DEFAULT
) (
    input  logic                          clk,
    input  logic                          i_reset,
    input  logic [NRD*$clog2(NREGS)-1:0]  i_rd_addr,
    output logic [NRD*N-1:0]              o_rd_data,
    output logic [NRD-1:0]                o_rd_busy,
    input  logic                          i_wa_en,
    input  logic [$clog2(NREGS)-1:0]      i_wa_addr,
    input  logic [N-1:0]                  i_wa_data,
    input  logic                          i_wb_en,
    input  logic [$clog2(NREGS)-1:0]      i_wb_addr,
    input  logic [N-1:0]                  i_wb_data,
    input  logic                          i_claim_en,
    input  logic [$clog2(NREGS)-1:0]      i_claim_addr,
    input  logic                          i_nzcv_en,
    input  logic [3:0]                    i_nzcv,
    output logic [3:0]                    o_nzcv,
    input  logic                          i_pc_en,
    input  logic                          i_br_en,
    input  logic [N-1:0]                  i_br_addr,
    output logic [N-1:0]                  o_pc
);

    localparam int            AW        = $clog2(NREGS);
    localparam logic [AW-1:0] c_PC_ADDR = AW'(NREGS - 1);

    logic [N-1:0]     r_regs [NREGS];
    logic [NREGS-1:0] r_busy;
    logic [N-1:0]     r_pc;
    nzcv_t            r_nzcv;

    logic [N-1:0]     w_pc_read;
    logic             w_wa_pc;
    logic             w_wb_pc;

    assign w_pc_read = r_pc + N'(2 * PC_STEP);
    assign w_wa_pc   = i_wa_en && (i_wa_addr == c_PC_ADDR);
    assign w_wb_pc   = i_wb_en && (i_wb_addr == c_PC_ADDR);

    // The top slot aliases the PC and is only ever cleared; r_pc holds the PC.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS - 1; i++) begin
                if (i_wa_en && (i_wa_addr == AW'(i))) begin
                    r_regs[i] <= i_wa_data;
                end else if (i_wb_en && (i_wb_addr == AW'(i))) begin
                    r_regs[i] <= i_wb_data;
                end
            end
        end
    end

    // A claim in the same cycle as a write belongs to the new owner, so it wins.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_busy <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (i_claim_en && (i_claim_addr == AW'(i))) begin
                    r_busy[i] <= 1'b1;
                end else if ((i_wa_en && (i_wa_addr == AW'(i))) ||
                             (i_wb_en && (i_wb_addr == AW'(i)))) begin
                    r_busy[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_pc <= '0;
        end else if (w_wa_pc) begin
            r_pc <= i_wa_data;
        end else if (w_wb_pc) begin
            r_pc <= i_wb_data;
        end else if (i_br_en) begin
            r_pc <= i_br_addr;
        end else if (i_pc_en) begin
            r_pc <= r_pc + N'(PC_STEP);
        end
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_nzcv <= '0;
        end else if (i_nzcv_en) begin
            r_nzcv <= i_nzcv;
        end
    end

    assign o_pc   = r_pc;
    assign o_nzcv = r_nzcv;

    for (genvar k = 0; k < NRD; k++) begin : g_rd_port
        logic [AW-1:0] w_addr;
        assign w_addr = i_rd_addr[k*AW +: AW];

        arm_rf_read_port #(
            .N       (N),
            .AW      (AW),
            .PC_ADDR (NREGS - 1)
        ) u_port (
            .i_addr       (w_addr),
            .i_stored     (r_regs[w_addr]),
            .i_pc_read    (w_pc_read),
            .i_busy       (r_busy[w_addr]),
            .i_wa_en      (i_wa_en),
            .i_wa_addr    (i_wa_addr),
            .i_wa_data    (i_wa_data),
            .i_wb_en      (i_wb_en),
            .i_wb_addr    (i_wb_addr),
            .i_wb_data    (i_wb_data),
            .i_claim_en   (i_claim_en),
            .i_claim_addr (i_claim_addr),
            .o_data       (o_rd_data[k*N +: N]),
            .o_busy       (o_rd_busy[k])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_arm_reg_bank_pipe.sv
// ============================================================================
// Module  : tb_arm_reg_bank_pipe
// Brief   : Directed and randomized self-checking bench for arm_reg_bank_pipe
//           against an array-based architectural model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_arm_reg_bank_pipe;

    localparam int N       = 32;
    localparam int NREGS   = 16;
    localparam int NRD     = 3;
    localparam int AW      = 4;
    localparam int PC_STEP = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [NRD*AW-1:0] rd_addr;
    logic [NRD*N-1:0]  rd_data;
    logic [NRD-1:0]    rd_busy;
    logic              wa_en, wb_en, claim_en, nzcv_en, pc_en, br_en;
    logic [AW-1:0]     wa_addr, wb_addr, claim_addr;
    logic [N-1:0]      wa_data, wb_data, br_addr;
    logic [3:0]        nzcv_in, nzcv_out;
    logic [N-1:0]      pc_out;

    always #5 clk = ~clk;

    arm_reg_bank_pipe #(
        .N       (N),
        .NREGS   (NREGS),
        .NRD     (NRD),
        .PC_STEP (PC_STEP)
    ) dut (
        .clk          (clk),
        .i_reset      (reset),
        .i_rd_addr    (rd_addr),
        .o_rd_data    (rd_data),
        .o_rd_busy    (rd_busy),
        .i_wa_en      (wa_en),
        .i_wa_addr    (wa_addr),
        .i_wa_data    (wa_data),
        .i_wb_en      (wb_en),
        .i_wb_addr    (wb_addr),
        .i_wb_data    (wb_data),
        .i_claim_en   (claim_en),
        .i_claim_addr (claim_addr),
        .i_nzcv_en    (nzcv_en),
        .i_nzcv       (nzcv_in),
        .o_nzcv       (nzcv_out),
        .i_pc_en      (pc_en),
        .i_br_en      (br_en),
        .i_br_addr    (br_addr),
        .o_pc         (pc_out)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [N-1:0]     m_regs [NREGS];
    logic [NREGS-1:0] m_busy;
    logic [N-1:0]     m_pc;
    logic [3:0]       m_nzcv;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] exp_read(input logic [AW-1:0] a);
        if (a == AW'(NREGS - 1)) return m_pc + N'(2 * PC_STEP);
        if (wa_en && wa_addr == a) return wa_data;
        if (wb_en && wb_addr == a) return wb_data;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        logic wr;
        wr = (wa_en && wa_addr == a) || (wb_en && wb_addr == a);
        return (m_busy[a] && !wr) || (claim_en && claim_addr == a);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
        m_busy = '0;
        m_pc   = '0;
        m_nzcv = '0;
    endtask

    // Architectural effect of one clock edge, applied in priority order.
    task automatic model_update();
        if (reset) begin
            model_reset();
            return;
        end
        if (wb_en && wb_addr != AW'(NREGS - 1)) m_regs[wb_addr] = wb_data;
        if (wa_en && wa_addr != AW'(NREGS - 1)) m_regs[wa_addr] = wa_data;
        if (wa_en) m_busy[wa_addr] = 1'b0;
        if (wb_en) m_busy[wb_addr] = 1'b0;
        if (claim_en) m_busy[claim_addr] = 1'b1;
        if (wa_en && wa_addr == AW'(NREGS - 1))      m_pc = wa_data;
        else if (wb_en && wb_addr == AW'(NREGS - 1)) m_pc = wb_data;
        else if (br_en)                              m_pc = br_addr;
        else if (pc_en)                              m_pc = m_pc + N'(PC_STEP);
        if (nzcv_en) m_nzcv = nzcv_in;
    endtask

    // Entered just after a posedge; checks comb outputs mid-cycle, then the edge.
    task automatic cycle();
        #4;
        for (int k = 0; k < NRD; k++) begin
            check("rd_data", rd_data[k*N +: N], exp_read(rd_addr[k*AW +: AW]));
            check("rd_busy", 32'(rd_busy[k]), 32'(exp_busy(rd_addr[k*AW +: AW])));
        end
        @(posedge clk);
        model_update();
        #1;
        check("pc", pc_out, m_pc);
        check("nzcv", 32'(nzcv_out), 32'(m_nzcv));
    endtask

    task automatic idle();
        reset = 1'b0; wa_en = 1'b0; wb_en = 1'b0; claim_en = 1'b0;
        nzcv_en = 1'b0; pc_en = 1'b0; br_en = 1'b0;
    endtask

    initial begin
        idle();
        rd_addr = '0; wa_addr = '0; wb_addr = '0; claim_addr = '0;
        wa_data = '0; wb_data = '0; br_addr = '0; nzcv_in = '0;
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        model_reset();
        #1;
        idle();

        // Reset dominates writes, claims, flags and PC events in the same cycle.
        wa_en = 1'b1; wa_addr = 4'd1; wa_data = 32'h5;
        nzcv_en = 1'b1; nzcv_in = 4'hF; pc_en = 1'b1;
        cycle();
        reset = 1'b1; wa_addr = 4'd2; wa_data = 32'h7; claim_en = 1'b1; claim_addr = 4'd2;
        cycle();
        idle();
        rd_addr = {4'd15, 4'd2, 4'd1};
        #1;
        check("rst_r1", rd_data[31:0], 32'h0);
        check("rst_r2", rd_data[63:32], 32'h0);
        check("rst_pcread", rd_data[95:64], 32'h8);
        check("rst_pc", pc_out, 32'h0);
        check("rst_nzcv", 32'(nzcv_out), 32'h0);
        check("rst_busy", 32'(rd_busy), 32'h0);
        cycle();

        // Zero-latency bypass, then the stored value.
        wa_en = 1'b1; wa_addr = 4'd3; wa_data = 32'hDEADBEEF; rd_addr = {4'd0, 4'd0, 4'd3};
        #1;
        check("byp", rd_data[31:0], 32'hDEADBEEF);
        cycle();
        idle();
        #1;
        check("byp_store", rd_data[31:0], 32'hDEADBEEF);
        cycle();

        // Same-address clash between the two write ports.
        wa_en = 1'b1; wa_addr = 4'd5; wa_data = 32'h11;
        wb_en = 1'b1; wb_addr = 4'd5; wb_data = 32'h22; rd_addr = {4'd0, 4'd0, 4'd5};
        #1;
        check("clash", rd_data[31:0], 32'h11);
        cycle();
        idle();
        #1;
        check("clash_store", rd_data[31:0], 32'h11);
        cycle();

        // Scoreboard set, clear, and claim-with-write.
        claim_en = 1'b1; claim_addr = 4'd7; rd_addr = {4'd0, 4'd0, 4'd7};
        #1;
        check("sb_claim", 32'(rd_busy[0]), 32'h1);
        cycle();
        idle();
        wb_en = 1'b1; wb_addr = 4'd7; wb_data = 32'h77;
        #1;
        check("sb_clear", 32'(rd_busy[0]), 32'h0);
        cycle();
        idle();
        claim_en = 1'b1; claim_addr = 4'd7; wa_en = 1'b1; wa_addr = 4'd7; wa_data = 32'h78;
        #1;
        check("sb_claim_wr", 32'(rd_busy[0]), 32'h1);
        cycle();
        idle();
        #1;
        check("sb_hold", 32'(rd_busy[0]), 32'h1);
        cycle();

        // PC advance, branch, and A write overriding a branch.
        reset = 1'b1;
        cycle();
        idle();
        pc_en = 1'b1;
        repeat (3) cycle();
        idle();
        rd_addr = {4'd0, 4'd0, 4'd15};
        #1;
        check("pc_adv", pc_out, 32'd12);
        check("pc_read", rd_data[31:0], 32'd20);
        cycle();
        br_en = 1'b1; br_addr = 32'h100; pc_en = 1'b1;
        cycle();
        idle();
        #1;
        check("pc_br", pc_out, 32'h100);
        wa_en = 1'b1; wa_addr = 4'd15; wa_data = 32'h200; br_en = 1'b1; br_addr = 32'h300;
        cycle();
        idle();
        #1;
        check("pc_wr", pc_out, 32'h200);
        cycle();

        // Flags load next cycle; reset suppresses a simultaneous load.
        nzcv_en = 1'b1; nzcv_in = 4'b0110;
        #1;
        check("nzcv_nobyp", 32'(nzcv_out), 32'h0);
        cycle();
        idle();
        #1;
        check("nzcv_load", 32'(nzcv_out), 32'h6);
        nzcv_en = 1'b1; nzcv_in = 4'b1001; reset = 1'b1;
        cycle();
        idle();
        #1;
        check("nzcv_rst", 32'(nzcv_out), 32'h0);
        cycle();

        // Randomized traffic with biased address collisions.
        for (int t = 0; t < 600; t++) begin
            reset      = ($urandom_range(0, 49) == 0);
            wa_en      = $urandom_range(0, 1) == 1;
            wa_addr    = AW'($urandom_range(0, NREGS - 1));
            wa_data    = $urandom;
            wb_en      = $urandom_range(0, 1) == 1;
            wb_addr    = ($urandom_range(0, 3) == 0) ? wa_addr : AW'($urandom_range(0, NREGS - 1));
            wb_data    = $urandom;
            claim_en   = $urandom_range(0, 2) == 0;
            claim_addr = ($urandom_range(0, 3) == 0) ? wa_addr : AW'($urandom_range(0, NREGS - 1));
            nzcv_en    = $urandom_range(0, 2) == 0;
            nzcv_in    = 4'($urandom);
            pc_en      = $urandom_range(0, 1) == 1;
            br_en      = $urandom_range(0, 7) == 0;
            br_addr    = $urandom;
            for (int k = 0; k < NRD; k++) begin
                case ($urandom_range(0, 4))
                    0:       rd_addr[k*AW +: AW] = wa_addr;
                    1:       rd_addr[k*AW +: AW] = wb_addr;
                    2:       rd_addr[k*AW +: AW] = claim_addr;
                    default: rd_addr[k*AW +: AW] = AW'($urandom_range(0, NREGS - 1));
                endcase
            end
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
